data_ram_arbiter: RTL and testbench
===================================

Name: data_ram_arbiter

Overview:
- Shares the single data_ram port between two requesters.
  - Master 0 (m0) is the CPU data port.
  - Master 1 (m1) is a DMA/debug loader.
- Sits between the openmips ram_* port, the loader and data_ram in the SOPC top.
- m0 has fixed priority, with two exceptions:
  - a starvation counter forces an m1 grant after a bounded wait;
  - m1 may lock the port for a bounded burst.
- Read data is registered and returned with a valid strobe one cycle after grant.

Parameters:
- ADDR_W, 32, address width (matches `DataAddrBus).
- DATA_W, 32, data width (matches `DataBus).
- M1_MAX_WAIT, 8, consecutive denied m1 cycles before m1 is forced a grant; legal range 1..255.
- M1_BURST_MAX, 4, maximum consecutive locked m1 grants while m0 is requesting; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- m0_req_i  in  1  CPU access request.
- m0_we_i  in  1  1 = write, 0 = read.
- m0_addr_i  in  ADDR_W  byte address.
- m0_sel_i  in  4  byte lane enables.
- m0_data_i  in  DATA_W  write data.
- m0_gnt_o  out  1  access accepted this cycle; CPU stall = m0_req_i & ~m0_gnt_o.
- m0_rvalid_o  out  1  read data valid (one cycle after a granted read).
- m0_rdata_o  out  DATA_W  registered read data.
- m1_req_i, m1_we_i, m1_addr_i, m1_sel_i, m1_data_i  in  1/1/ADDR_W/4/DATA_W  same meaning for m1.
- m1_lock_i  in  1  m1 requests to keep the port for its next beat (burst).
- m1_gnt_o, m1_rvalid_o, m1_rdata_o  out  1/1/DATA_W  same meaning for m1.
- ram_ce_o  out  1  to data_ram ce.
- ram_we_o  out  1  to data_ram we.
- ram_addr_o  out  ADDR_W  to data_ram addr.
- ram_sel_o  out  4  to data_ram sel.
- ram_data_o  out  DATA_W  to data_ram data_i.
- ram_data_i  in  DATA_W  from data_ram data_o (combinational read).

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset:
  - wait_cnt, burst_cnt, lock_own, both rvalid flags and both rdata registers clear to 0.
  - All grants and ram_* outputs evaluate to 0 while rst = 1.
- Grant decision is combinational in cycle N from the requests and registered state:
  - force_m1 = m1_req_i & (wait_cnt >= M1_MAX_WAIT).
  - keep_m1 = m1_req_i & lock_own & (burst_cnt < M1_BURST_MAX).
  - m1_gnt_o = m1_req_i & (~m0_req_i | force_m1 | keep_m1).
  - m0_gnt_o = m0_req_i & ~m1_gnt_o.
  - At most one grant per cycle (one-hot or zero).
- RAM drive in cycle N:
  - Granted master's we/addr/sel/data are muxed to ram_*, with ram_ce_o = 1.
  - No grant: ram_ce_o = 0 and all other ram_* outputs = 0.
- Write: data_ram commits at the end of cycle N; no rvalid is produced.
- Read: ram_data_i is captured at the end of cycle N into the granted master's rdata register; that master's rvalid_o = 1 in cycle N+1 only.
  - rdata holds its value until the next granted read for that master.
- Throughput: back-to-back grants are allowed; one access per cycle, zero bubble.
- wait_cnt (8-bit):
  - increments when m1_req_i & ~m1_gnt_o, saturating at 255;
  - clears on m1 grant or when m1_req_i = 0.
- lock_own: set to m1_lock_i at the end of any m1-granted cycle; cleared on any cycle with no m1 grant.
- burst_cnt:
  - increments on an m1 grant while m0_req_i = 1 and lock_own = 1;
  - clears when lock_own ends or on an m1 grant with m0 idle.
  - On reaching M1_BURST_MAX, m0 wins the next contended cycle.
- States (encoded by lock_own/counters): IDLE (no grant), M0 (CPU owns), M1 (loader single beat), M1_LOCK (loader burst).
- Boundary conditions:
  - Both requesting, counters 0, no lock: m0 wins and wait_cnt increments.
  - force_m1 and m0 requesting in the same cycle: m1 wins; the CPU stalls exactly that cycle.
  - m1 drops its request mid-burst: the lock is released the next cycle and the CPU is served immediately.
  - A requester may deassert req before being granted (no penalty); it must hold its signals stable while req = 1 and ungranted.
  - rst asserted while an rvalid is pending: rvalid is suppressed the next cycle and the data is lost.

Decomposition:
- Add to defines.h:
  - `ArbM0 / `ArbM1 owner encodings;
  - `ArbWaitBus (7:0);
  - `ArbBurstBus (3:0);
  - reuse `DataAddrBus / `DataBus.
- One natural sub-module, arb_wait_counter: the saturating wait counter plus the force_m1 comparator.
- Mux, grant logic and rdata registers stay in the top block.
- SOPC top instantiates data_ram_arbiter between openmips0 and data_ram0.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with both reqs = 1 -> gnt = 0, ram_ce_o = 0, rvalid = 0; after release, m0 is granted on the first cycle.
- Priority and starvation (M1_MAX_WAIT = 8):
  - m0 and m1 read continuously -> m0 granted 8 cycles, m1 granted on cycle 9, m0 on cycle 10, pattern repeats;
  - m1_rvalid_o pulses on cycle 10 with RAM[m1_addr].
- Write then read: m0 writes 0xDEADBEEF, sel = 4'b1111 to addr 0x40; m1 reads 0x40 next cycle -> m1_rvalid_o one cycle later with 0xDEADBEEF.
- Burst lock (M1_BURST_MAX = 4): m1 lock_i = 1 with 6 beats, m0 requesting from beat 2 -> m1 granted on beats 1..5, then m0 granted; m1 beat 6 waits.
- Idle and retraction: m1 req pulses 1 cycle while m0 is busy, then drops -> wait_cnt returns to 0, no m1 grant, ram_ce_o follows m0 only.
- Mid-read reset: rst asserted in the cycle after a granted m0 read -> m0_rvalid_o stays 0 that cycle and m0_rdata_o = 0.

Source files
------------

// File: rtl/data_ram_arbiter_pkg.sv
// Shared types and helpers for the data_ram arbiter: owner encoding,
// counter widths and saturating increments.
package data_ram_arbiter_pkg;

  localparam int ARB_WAIT_W  = 8;
  localparam int ARB_BURST_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  function automatic logic [ARB_WAIT_W-1:0] sat_inc_wait(input logic [ARB_WAIT_W-1:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [ARB_BURST_W-1:0] sat_inc_burst(input logic [ARB_BURST_W-1:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/data_ram_arbiter_wait_counter.sv
// Starvation guard for the loader port: counts consecutive denied m1 cycles
// and forces an m1 grant once the bound is reached.
module arb_wait_counter
  import data_ram_arbiter_pkg::*;
#(
  parameter int M1_MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic m1_req,
  input  logic m1_gnt,
  output logic force_m1
);

  logic [ARB_WAIT_W-1:0] wait_cnt_r;

  // Count denied cycles; any grant or retraction restarts the wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= 8'd0;
    end else if (m1_req && !m1_gnt) begin
      wait_cnt_r <= sat_inc_wait(wait_cnt_r);
    end else begin
      wait_cnt_r <= 8'd0;
    end
  end

  assign force_m1 = m1_req & (wait_cnt_r >= ARB_WAIT_W'(M1_MAX_WAIT));

endmodule

// File: rtl/data_ram_arbiter.sv
// Two-master arbiter for the single data_ram port: CPU (m0) has priority,
// loader (m1) gets a starvation-forced grant and bounded burst locking.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int M1_MAX_WAIT  = 8,
  parameter int M1_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [DATA_W-1:0] m1_data_i,
  input  logic              m1_lock_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  logic                   force_m1_s;
  logic                   keep_m1_s;
  logic                   m0_gnt_s;
  logic                   m1_gnt_s;
  owner_e                 owner_s;
  logic                   lock_own_r;
  logic [ARB_BURST_W-1:0] burst_cnt_r;
  logic                   m0_rvalid_r;
  logic                   m1_rvalid_r;
  logic [DATA_W-1:0]      m0_rdata_r;
  logic [DATA_W-1:0]      m1_rdata_r;

  arb_wait_counter #(
    .M1_MAX_WAIT (M1_MAX_WAIT)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .m1_req   (m1_req_i),
    .m1_gnt   (m1_gnt_s),
    .force_m1 (force_m1_s)
  );

  // Grants are masked while rst is high so the RAM sees no access during reset.
  assign keep_m1_s = m1_req_i & lock_own_r & (burst_cnt_r < ARB_BURST_W'(M1_BURST_MAX));
  assign m1_gnt_s  = ~rst & m1_req_i & (~m0_req_i | force_m1_s | keep_m1_s);
  assign m0_gnt_s  = ~rst & m0_req_i & ~m1_gnt_s;
  assign m0_gnt_o  = m0_gnt_s;
  assign m1_gnt_o  = m1_gnt_s;

  // Resolve which master drives the RAM this cycle.
  always_comb begin
    owner_s = OWN_NONE;
    if (m1_gnt_s) begin
      owner_s = OWN_M1;
    end else if (m0_gnt_s) begin
      owner_s = OWN_M0;
    end else begin
      owner_s = OWN_NONE;
    end
  end

  // RAM port mux; an idle port is driven fully to zero.
  always_comb begin
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_sel_o  = 4'b0000;
    ram_data_o = '0;
    case (owner_s)
      OWN_M0: begin
        ram_ce_o   = 1'b1;
        ram_we_o   = m0_we_i;
        ram_addr_o = m0_addr_i;
        ram_sel_o  = m0_sel_i;
        ram_data_o = m0_data_i;
      end
      OWN_M1: begin
        ram_ce_o   = 1'b1;
        ram_we_o   = m1_we_i;
        ram_addr_o = m1_addr_i;
        ram_sel_o  = m1_sel_i;
        ram_data_o = m1_data_i;
      end
      default: begin
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_sel_o  = 4'b0000;
        ram_data_o = '0;
      end
    endcase
  end

  // Burst ownership: the lock survives only across m1-granted cycles, and the
  // beat count only advances while the CPU is actually being held off.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_own_r  <= 1'b0;
      burst_cnt_r <= 4'd0;
    end else begin
      lock_own_r <= m1_gnt_s & m1_lock_i;
      if (m1_gnt_s && m1_lock_i && m0_req_i && lock_own_r) begin
        burst_cnt_r <= sat_inc_burst(burst_cnt_r);
      end else begin
        burst_cnt_r <= 4'd0;
      end
    end
  end

  // Read return path: capture RAM data for the granted reader, strobe next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rvalid_r <= 1'b0;
      m1_rvalid_r <= 1'b0;
      m0_rdata_r  <= '0;
      m1_rdata_r  <= '0;
    end else begin
      m0_rvalid_r <= m0_gnt_s & ~m0_we_i;
      m1_rvalid_r <= m1_gnt_s & ~m1_we_i;
      if (m0_gnt_s && !m0_we_i) begin
        m0_rdata_r <= ram_data_i;
      end
      if (m1_gnt_s && !m1_we_i) begin
        m1_rdata_r <= ram_data_i;
      end
    end
  end

  // A reset arriving while a read is in flight drops that read immediately.
  assign m0_rvalid_o = m0_rvalid_r & ~rst;
  assign m1_rvalid_o = m1_rvalid_r & ~rst;
  assign m0_rdata_o  = rst ? '0 : m0_rdata_r;
  assign m1_rdata_o  = rst ? '0 : m1_rdata_r;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for data_ram_arbiter: a cycle-level reference model of
// the arbitration rules plus directed scenarios with literal expectations.
module tb_data_ram_arbiter;

  localparam int MAXW = 8;
  localparam int BMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_data, m1_addr, m1_data;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;

  logic [31:0] ram     [0:63];
  logic [31:0] ref_mem [0:63];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_ram_arbiter #(
    .ADDR_W(32), .DATA_W(32), .M1_MAX_WAIT(MAXW), .M1_BURST_MAX(BMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_sel_i(m0_sel),
    .m0_data_i(m0_data), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_sel_i(m1_sel),
    .m1_data_i(m1_data), .m1_lock_i(m1_lock),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_sel_o(ram_sel),
    .ram_data_o(ram_wdata), .ram_data_i(ram_rdata)
  );

  // data_ram stand-in: combinational read, byte-lane write at the clock edge.
  assign ram_rdata = ram[ram_addr[7:2]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'hA500_0000 | i;
    end else if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) ram[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int          m_wait = 0;
  int          m_burst = 0;
  bit          m_lock = 1'b0;
  bit          e_rv0 = 1'b0, e_rv1 = 1'b0;
  logic [31:0] e_rd0 = 32'h0, e_rd1 = 32'h0;
  bit          g0, g1, e_ce, e_we;
  logic [31:0] e_addr, e_wd;
  logic [3:0]  e_sel;

  // Model-vs-DUT compare, once per cycle on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      g1 = 1'b0;
      g0 = 1'b0;
    end else begin
      g1 = m1_req && (!m0_req || (m_wait >= MAXW) || (m_lock && (m_burst < BMAX)));
      g0 = m0_req && !g1;
    end
    e_ce = g0 || g1;
    e_we = 1'b0; e_addr = 32'h0; e_sel = 4'h0; e_wd = 32'h0;
    if (g1) begin
      e_we = m1_we; e_addr = m1_addr; e_sel = m1_sel; e_wd = m1_data;
    end else if (g0) begin
      e_we = m0_we; e_addr = m0_addr; e_sel = m0_sel; e_wd = m0_data;
    end
    check("m0_gnt", m0_gnt, g0);
    check("m1_gnt", m1_gnt, g1);
    check("ram_ce", ram_ce, e_ce);
    check("ram_we", ram_we, e_we);
    check("ram_addr", ram_addr, e_addr);
    check("ram_sel", ram_sel, e_sel);
    check("ram_data", ram_wdata, e_wd);
    check("m0_rvalid", m0_rvalid, rst ? 1'b0 : e_rv0);
    check("m1_rvalid", m1_rvalid, rst ? 1'b0 : e_rv1);
    check("m0_rdata", m0_rdata, rst ? 32'h0 : e_rd0);
    check("m1_rdata", m1_rdata, rst ? 32'h0 : e_rd1);
    if (rst) begin
      m_wait = 0; m_burst = 0; m_lock = 1'b0;
      e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = 32'h0; e_rd1 = 32'h0;
      for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA500_0000 | i;
    end else begin
      if (g1 && m1_lock)
        m_burst = (m0_req && m_lock) ? ((m_burst < 15) ? m_burst + 1 : 15) : 0;
      else
        m_burst = 0;
      m_lock = g1 && m1_lock;
      m_wait = (m1_req && !g1) ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
      e_rv0 = g0 && !m0_we;
      e_rv1 = g1 && !m1_we;
      if (e_rv0) e_rd0 = ref_mem[m0_addr[7:2]];
      if (e_rv1) e_rd1 = ref_mem[m1_addr[7:2]];
      if (e_ce && e_we)
        for (int b = 0; b < 4; b++)
          if (e_sel[b]) ref_mem[e_addr[7:2]][8*b +: 8] = e_wd[8*b +: 8];
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_m1, second_m1, m1_cnt, beat, n;
    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20; m0_sel = 4'hF; m0_data = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10; m1_sel = 4'hF; m1_data = 32'h0;
    m1_lock = 1'b0;

    // Reset with both masters requesting
    repeat (2) begin
      @(negedge clk);
      check("rst_m0_gnt", m0_gnt, 1'b0);
      check("rst_m1_gnt", m1_gnt, 1'b0);
      check("rst_ce", ram_ce, 1'b0);
      next_cycle();
    end
    next_cycle();
    rst = 1'b0;

    // Continuous contention: m1 forced in every 9th cycle
    first_m1 = 0; second_m1 = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) check("first_after_rst_m0", m0_gnt, 1'b1);
      if (m1_gnt) begin
        if (first_m1 == 0) first_m1 = c;
        else if (second_m1 == 0) second_m1 = c;
      end
      if (c == 10) begin
        check("starve_rvalid", m1_rvalid, 1'b1);
        check("starve_rdata", m1_rdata, 32'hA500_0004);
      end
      next_cycle();
    end
    check("starve_first_m1", first_m1, 9);
    check("starve_second_m1", second_m1, 18);

    // Full write by m0, then m1 reads it back
    m1_req = 1'b0;
    m0_we = 1'b1; m0_addr = 32'h40; m0_data = 32'hDEAD_BEEF; m0_sel = 4'hF;
    @(negedge clk); check("wr_m0_gnt", m0_gnt, 1'b1); next_cycle();
    m0_req = 1'b0; m0_we = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h40;
    @(negedge clk); check("rd_m1_gnt", m1_gnt, 1'b1); next_cycle();
    m1_req = 1'b0;
    @(negedge clk);
    check("wr_rd_rvalid", m1_rvalid, 1'b1);
    check("wr_rd_data", m1_rdata, 32'hDEAD_BEEF);
    next_cycle();

    // Partial-lane write then read
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h44; m0_data = 32'h1234_5678; m0_sel = 4'b0011;
    next_cycle();
    m0_we = 1'b0; m0_sel = 4'hF;
    next_cycle();
    m0_req = 1'b0;
    @(negedge clk); check("sel_rdata", m0_rdata, 32'hA500_5678); next_cycle();

    // Locked burst: m0 joins from beat 2, m1 keeps the port for 5 beats
    m1_req = 1'b1; m1_lock = 1'b1; m1_we = 1'b0;
    m1_cnt = 0; beat = 0;
    for (int b = 1; b <= 6; b++) begin
      m0_req = (b >= 2); m0_we = 1'b0; m0_addr = 32'h24;
      m1_addr = 32'h80 + beat * 4;
      @(negedge clk);
      if (m1_gnt) begin m1_cnt++; beat++; end
      if (b == 6) check("burst_m0_wins", m0_gnt, 1'b1);
      next_cycle();
    end
    check("burst_m1_beats", m1_cnt, 5);
    m0_req = 1'b0; m1_addr = 32'h80 + beat * 4;
    @(negedge clk); check("burst_last_beat", m1_gnt, 1'b1); next_cycle();
    // m1 drops while holding the lock: CPU served at once, lock gone
    m1_req = 1'b0; m0_req = 1'b1;
    @(negedge clk); check("drop_m0_served", m0_gnt, 1'b1); next_cycle();
    m1_req = 1'b1; m1_lock = 1'b0;
    @(negedge clk); check("lock_released", m1_gnt, 1'b0); next_cycle();

    // Retraction: a one-cycle m1 pulse leaves no wait credit behind
    m1_req = 1'b0; next_cycle();
    m1_req = 1'b1; m1_addr = 32'h2C;
    @(negedge clk); check("pulse_no_gnt", m1_gnt, 1'b0); next_cycle();
    m1_req = 1'b0;
    repeat (3) next_cycle();
    m1_req = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m1_gnt) break;
      n++;
      next_cycle();
    end
    check("retract_wait_reset", n, 8);
    next_cycle();

    // Reset lands on the cycle after a granted read
    m1_req = 1'b0; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
    @(negedge clk); check("midrst_gnt", m0_gnt, 1'b1); next_cycle();
    rst = 1'b1; m0_req = 1'b0;
    @(negedge clk);
    check("midrst_rvalid", m0_rvalid, 1'b0);
    check("midrst_rdata", m0_rdata, 32'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk); check("midrst_lost", m0_rvalid, 1'b0); next_cycle();
    m0_req = 1'b1;
    next_cycle();
    m0_req = 1'b0;
    @(negedge clk); check("post_rst_rdata", m0_rdata, 32'hA500_0010); next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
